// File: rtl/ibus_dbus_arbiter.sv
// Shares one pipelined Avalon-MM port between instruction fetch (ibus) and the LSU (dbus).
// A small ID FIFO routes each read response back to the requester that issued it.
module ibus_dbus_arbiter #(
    parameter int unsigned AW              = 32,
    parameter int unsigned DW              = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic            clk,
    input  logic            rst_b,

    input  logic            ibus_read,
    input  logic [AW-1:0]   ibus_address,
    output logic            ibus_waitrequest,
    output logic [DW-1:0]   ibus_readdata,
    output logic            ibus_readdatavalid,

    input  logic            dbus_read,
    input  logic            dbus_write,
    input  logic [AW-1:0]   dbus_address,
    input  logic [DW-1:0]   dbus_writedata,
    input  logic [DW/8-1:0] dbus_byteenable,
    output logic            dbus_waitrequest,
    output logic [DW-1:0]   dbus_readdata,
    output logic            dbus_readdatavalid,

    output logic            avn_read,
    output logic            avn_write,
    output logic [AW-1:0]   avn_address,
    output logic [DW-1:0]   avn_writedata,
    output logic [DW/8-1:0] avn_byteenable,
    input  logic            avn_waitrequest,
    input  logic [DW-1:0]   avn_readdata,
    input  logic            avn_readdatavalid,

    output logic            resp_error
);

    localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e                     state_q, state_d;
    logic                       owner_q, owner_d;     // 1 = dbus
    logic [SW-1:0]              starve_q, starve_d;
    logic [MAX_OUTSTANDING-1:0] id_q, id_d;           // 1 = dbus
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       resp_error_q, resp_error_d;

    logic dbus_req;
    logic pop;
    logic push;
    logic blocked;
    logic issue;
    logic sel_dbus;
    logic accept;
    logic ibus_acc;
    logic dbus_acc;
    logic head_dbus;

    assign dbus_req  = dbus_read | dbus_write;
    assign pop       = avn_readdatavalid & (count_q != '0);
    // A response popping this cycle frees a slot for a read issued in the same cycle.
    assign blocked   = (count_q == CW'(MAX_OUTSTANDING)) & ~pop;
    assign head_dbus = id_q[rd_ptr_q];

    always_comb begin
        issue    = 1'b0;
        sel_dbus = 1'b0;
        if (state_q == StHold) begin
            issue    = 1'b1;
            sel_dbus = owner_q;
        end else if (!blocked && (ibus_read || dbus_req)) begin
            issue    = 1'b1;
            sel_dbus = dbus_req && !(ibus_read && (starve_q == SW'(STARVE_LIMIT)));
        end
        if (!rst_b) begin
            issue = 1'b0;
        end
    end

    assign accept   = issue & ~avn_waitrequest;
    assign ibus_acc = accept & ~sel_dbus;
    assign dbus_acc = accept & sel_dbus;
    assign push     = accept & avn_read;

    assign avn_read       = issue & (sel_dbus ? dbus_read : ibus_read);
    assign avn_write      = issue & sel_dbus & dbus_write;
    assign avn_address    = sel_dbus ? dbus_address : ibus_address;
    assign avn_byteenable = sel_dbus ? dbus_byteenable : {(DW/8){1'b1}};
    assign avn_writedata  = dbus_writedata;

    // Whoever is not accepted waits, unless the bus is idle and a slot is free.
    assign ibus_waitrequest = ~ibus_acc & (~rst_b | issue | blocked);
    assign dbus_waitrequest = ~dbus_acc & (~rst_b | issue | blocked);

    assign ibus_readdata      = avn_readdata;
    assign dbus_readdata      = avn_readdata;
    assign ibus_readdatavalid = pop & ~head_dbus;
    assign dbus_readdatavalid = pop & head_dbus;
    assign resp_error         = resp_error_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            StIdle: begin
                if (issue && avn_waitrequest) begin
                    state_d = StHold;
                    owner_d = sel_dbus;
                end
            end
            StHold: begin
                if (!avn_waitrequest) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (ibus_acc || !ibus_read) begin
            starve_d = '0;
        end else if (dbus_acc && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_comb begin
        id_d     = id_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            id_d[wr_ptr_q] = sel_dbus;
            wr_ptr_d       = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d      = count_q + CW'(push) - CW'(pop);
        resp_error_d = resp_error_q | (avn_readdatavalid & (count_q == '0));
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            starve_q     <= '0;
            id_q         <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_q     <= starve_d;
            id_q         <= id_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            resp_error_q <= resp_error_d;
        end
    end

endmodule

// File: tb/tb_ibus_dbus_arbiter.sv
// Directed bench for ibus_dbus_arbiter: expected commands and responses are queued by the
// stimulus and consumed by independent monitors on the avn command and readdatavalid outputs.
module tb_ibus_dbus_arbiter;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        ibus_read;
    logic [31:0] ibus_address;
    logic        ibus_waitrequest;
    logic [31:0] ibus_readdata;
    logic        ibus_readdatavalid;
    logic        dbus_read;
    logic        dbus_write;
    logic [31:0] dbus_address;
    logic [31:0] dbus_writedata;
    logic [3:0]  dbus_byteenable;
    logic        dbus_waitrequest;
    logic [31:0] dbus_readdata;
    logic        dbus_readdatavalid;
    logic        avn_read;
    logic        avn_write;
    logic [31:0] avn_address;
    logic [31:0] avn_writedata;
    logic [3:0]  avn_byteenable;
    logic        avn_waitrequest;
    logic [31:0] avn_readdata;
    logic        avn_readdatavalid;
    logic        resp_error;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } cmd_t;

    typedef struct {
        logic        to_dbus;
        logic [31:0] data;
    } resp_t;

    cmd_t  cmd_q[$];
    resp_t resp_q[$];
    cmd_t  mon_cmd;
    resp_t mon_resp;
    int    checks = 0;
    int    errors = 0;

    ibus_dbus_arbiter #(
        .AW(32), .DW(32), .MAX_OUTSTANDING(4), .STARVE_LIMIT(4)
    ) dut (
        .clk                (clk),
        .rst_b              (rst_b),
        .ibus_read          (ibus_read),
        .ibus_address       (ibus_address),
        .ibus_waitrequest   (ibus_waitrequest),
        .ibus_readdata      (ibus_readdata),
        .ibus_readdatavalid (ibus_readdatavalid),
        .dbus_read          (dbus_read),
        .dbus_write         (dbus_write),
        .dbus_address       (dbus_address),
        .dbus_writedata     (dbus_writedata),
        .dbus_byteenable    (dbus_byteenable),
        .dbus_waitrequest   (dbus_waitrequest),
        .dbus_readdata      (dbus_readdata),
        .dbus_readdatavalid (dbus_readdatavalid),
        .avn_read           (avn_read),
        .avn_write          (avn_write),
        .avn_address        (avn_address),
        .avn_writedata      (avn_writedata),
        .avn_byteenable     (avn_byteenable),
        .avn_waitrequest    (avn_waitrequest),
        .avn_readdata       (avn_readdata),
        .avn_readdatavalid  (avn_readdatavalid),
        .resp_error         (resp_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_cmd(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
        cmd_t c;
        c.rd = rd; c.wr = wr; c.addr = addr; c.be = be; c.wd = wd;
        cmd_q.push_back(c);
    endtask

    task automatic respond(input logic to_dbus, input logic [31:0] data);
        resp_t r;
        r.to_dbus = to_dbus;
        r.data    = data;
        resp_q.push_back(r);
        avn_readdatavalid = 1'b1;
        avn_readdata      = data;
    endtask

    // Command monitor: every accepted avn command must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_b && (avn_read || avn_write) && !avn_waitrequest) begin
            check("cmd_pending", 64'(cmd_q.size() != 0), 64'd1);
            if (cmd_q.size() != 0) begin
                mon_cmd = cmd_q.pop_front();
                check("cmd_read", 64'(avn_read), 64'(mon_cmd.rd));
                check("cmd_write", 64'(avn_write), 64'(mon_cmd.wr));
                check("cmd_addr", 64'(avn_address), 64'(mon_cmd.addr));
                check("cmd_be", 64'(avn_byteenable), 64'(mon_cmd.be));
                if (mon_cmd.wr) check("cmd_wdata", 64'(avn_writedata), 64'(mon_cmd.wd));
            end
        end
    end

    // Response monitor: each readdatavalid pulse must go to the queued requester with its data.
    always @(negedge clk) begin
        if (ibus_readdatavalid || dbus_readdatavalid) begin
            check("resp_pending", 64'(resp_q.size() != 0), 64'd1);
            if (resp_q.size() != 0) begin
                mon_resp = resp_q.pop_front();
                check("resp_dest", 64'({ibus_readdatavalid, dbus_readdatavalid}),
                      mon_resp.to_dbus ? 64'd1 : 64'd2);
                check("resp_data", mon_resp.to_dbus ? 64'(dbus_readdata) : 64'(ibus_readdata),
                      64'(mon_resp.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b = 1'b0;
        ibus_read = 1'b0; ibus_address = '0;
        dbus_read = 1'b0; dbus_write = 1'b0; dbus_address = '0;
        dbus_writedata = '0; dbus_byteenable = '0;
        avn_waitrequest = 1'b0; avn_readdata = '0; avn_readdatavalid = 1'b0;

        // Reset and release
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ibus_wait", 64'(ibus_waitrequest), 64'd1);
        check("rst_dbus_wait", 64'(dbus_waitrequest), 64'd1);
        check("rst_avn_rw", 64'({avn_read, avn_write}), 64'd0);
        tick();
        rst_b = 1'b1;
        @(negedge clk);
        check("rel_ibus_wait", 64'(ibus_waitrequest), 64'd0);
        check("rel_dbus_wait", 64'(dbus_waitrequest), 64'd0);
        check("rel_avn_rw", 64'({avn_read, avn_write}), 64'd0);
        check("rel_resp_error", 64'(resp_error), 64'd0);

        // Simultaneous requests: dbus first, ibus next cycle, responses in order
        tick();
        ibus_read = 1'b1; ibus_address = 32'h100;
        dbus_read = 1'b1; dbus_address = 32'h200; dbus_byteenable = 4'h3;
        exp_cmd(1'b1, 1'b0, 32'h200, 4'h3, 32'h0);
        exp_cmd(1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
        @(negedge clk);
        check("arb_dbus_wait", 64'(dbus_waitrequest), 64'd0);
        check("arb_ibus_wait", 64'(ibus_waitrequest), 64'd1);
        tick();
        dbus_read = 1'b0;
        @(negedge clk);
        check("arb_ibus_wait2", 64'(ibus_waitrequest), 64'd0);
        tick();
        ibus_read = 1'b0;
        respond(1'b1, 32'hAAAA_0001);
        tick();
        respond(1'b0, 32'hBBBB_0002);
        tick();
        avn_readdatavalid = 1'b0;

        // Back-pressure: dbus held in HOLD for 3 cycles, ibus kept waiting
        dbus_read = 1'b1; dbus_address = 32'h300; dbus_byteenable = 4'hF;
        ibus_read = 1'b1; ibus_address = 32'h400;
        exp_cmd(1'b1, 1'b0, 32'h300, 4'hF, 32'h0);
        exp_cmd(1'b1, 1'b0, 32'h400, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            avn_waitrequest = (i < 3);
            @(negedge clk);
            check("hold_addr", 64'(avn_address), 64'h300);
            check("hold_read", 64'(avn_read), 64'd1);
            check("hold_ibus_wait", 64'(ibus_waitrequest), 64'd1);
            check("hold_dbus_wait", 64'(dbus_waitrequest), 64'(i < 3));
            tick();
        end
        dbus_read = 1'b0;
        @(negedge clk);
        check("hold_ibus_after", 64'(ibus_waitrequest), 64'd0);
        tick();
        ibus_read = 1'b0;
        respond(1'b1, 32'hCCCC_0003);
        tick();
        respond(1'b0, 32'hDDDD_0004);
        tick();
        avn_readdatavalid = 1'b0;

        // Starvation: 4 dbus writes, forced ibus grant, dbus resumes
        ibus_read = 1'b1; ibus_address = 32'h500;
        for (int i = 0; i < 4; i++)
            exp_cmd(1'b0, 1'b1, 32'h600 + 32'(4 * i), 4'h5, 32'hD000 + 32'(i));
        exp_cmd(1'b1, 1'b0, 32'h500, 4'hF, 32'h0);
        exp_cmd(1'b0, 1'b1, 32'h610, 4'h5, 32'hD004);
        for (int i = 0; i < 6; i++) begin
            dbus_write      = 1'b1;
            dbus_address    = 32'h600 + 32'(4 * ((i < 4) ? i : 4));
            dbus_writedata  = 32'hD000 + 32'((i < 4) ? i : 4);
            dbus_byteenable = 4'h5;
            if (i == 5) ibus_read = 1'b0;
            @(negedge clk);
            check("starve_dbus_wait", 64'(dbus_waitrequest), 64'(i == 4));
            if (i < 5) check("starve_ibus_wait", 64'(ibus_waitrequest), 64'(i != 4));
            tick();
        end
        dbus_write = 1'b0;
        respond(1'b0, 32'hEEEE_0005);
        tick();
        avn_readdatavalid = 1'b0;

        // FIFO full: 5th read waits, then issues alongside a response pop
        for (int i = 0; i < 4; i++) begin
            dbus_read = 1'b1; dbus_address = 32'h700 + 32'(4 * i); dbus_byteenable = 4'hF;
            exp_cmd(1'b1, 1'b0, 32'h700 + 32'(4 * i), 4'hF, 32'h0);
            @(negedge clk);
            tick();
        end
        dbus_address = 32'h710;
        @(negedge clk);
        check("full_dbus_wait", 64'(dbus_waitrequest), 64'd1);
        check("full_avn_read", 64'(avn_read), 64'd0);
        tick();
        exp_cmd(1'b1, 1'b0, 32'h710, 4'hF, 32'h0);
        respond(1'b1, 32'hF0F0_0006);
        @(negedge clk);
        check("full_pop_accept", 64'(dbus_waitrequest), 64'd0);
        check("full_pop_rdv", 64'(dbus_readdatavalid), 64'd1);
        tick();
        avn_readdatavalid = 1'b0;
        dbus_address = 32'h714;
        @(negedge clk);
        check("full_still", 64'(dbus_waitrequest), 64'd1);
        tick();
        dbus_read = 1'b0;
        for (int j = 0; j < 4; j++) begin
            respond(1'b1, 32'h6000_0000 + 32'(j));
            tick();
        end
        avn_readdatavalid = 1'b0;

        // Response with nothing outstanding
        avn_readdatavalid = 1'b1; avn_readdata = 32'h0BAD_0BAD;
        @(negedge clk);
        check("orphan_rdv", 64'({ibus_readdatavalid, dbus_readdatavalid}), 64'd0);
        tick();
        avn_readdatavalid = 1'b0;
        @(negedge clk);
        check("orphan_error", 64'(resp_error), 64'd1);
        repeat (3) tick();
        @(negedge clk);
        check("orphan_sticky", 64'(resp_error), 64'd1);

        // Reset mid-transfer clears the FIFO; the late response is an orphan
        tick();
        dbus_read = 1'b1; dbus_address = 32'h800;
        exp_cmd(1'b1, 1'b0, 32'h800, 4'hF, 32'h0);
        @(negedge clk);
        tick();
        dbus_read = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check("midrst_error_clr", 64'(resp_error), 64'd0);
        check("midrst_ibus_wait", 64'(ibus_waitrequest), 64'd1);
        tick();
        rst_b = 1'b1;
        avn_readdatavalid = 1'b1; avn_readdata = 32'h1A7E_1A7E;
        @(negedge clk);
        check("late_rdv", 64'({ibus_readdatavalid, dbus_readdatavalid}), 64'd0);
        tick();
        avn_readdatavalid = 1'b0;
        @(negedge clk);
        check("late_error", 64'(resp_error), 64'd1);

        check("cmd_queue_drained", 64'(cmd_q.size()), 64'd0);
        check("resp_queue_drained", 64'(resp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
